// File: rtl/token_run_pkg.sv
// Shared defaults and the FIFO entry layout for the token run-length counter.
package token_run_pkg;

    localparam int unsigned DefaultLenW  = 9;
    localparam int unsigned DefaultDepth = 4;

    typedef struct packed {
        logic                   sat;
        logic [DefaultLenW-1:0] len;
    } run_entry_t;

endpackage

// File: rtl/token_run_counter_if.sv
// Valid/ready channel that carries completed run lengths to the parallel consumer.
interface token_run_counter_if
    import token_run_pkg::*;
#(
    parameter int unsigned LEN_W = DefaultLenW
) ();

    logic             run_valid;
    logic             run_ready;
    logic [LEN_W-1:0] run_len;
    logic             run_sat;

    modport master (
        output run_valid,
        output run_len,
        output run_sat,
        input  run_ready
    );

    modport slave (
        input  run_valid,
        input  run_len,
        input  run_sat,
        output run_ready
    );

endinterface

// File: rtl/token_run_fifo.sv
// Show-ahead FIFO with async reset; head reads as zero while empty.
module token_run_fifo #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] entry_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = entry_i;
            wptr_d        = wptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AddrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/token_run_counter.sv
// Measures runs of consecutive '1's on a serial stream and queues their lengths.
// Optional TOKEN_RUN_FLUSH_EN adds a flush input that closes the current run early.
module token_run_counter
    import token_run_pkg::*;
#(
    parameter int unsigned LEN_W = DefaultLenW,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a,
`ifdef TOKEN_RUN_FLUSH_EN
    input  logic                flush,
`endif
    token_run_counter_if.master run_if,
    output logic                drop_err
);

    localparam int unsigned      EntryW = LEN_W + 1;
    localparam logic [LEN_W-1:0] CntMax = '1;

    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              drop_err_q, drop_err_d;
    logic              end_run;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [EntryW-1:0] push_entry;
    logic [EntryW-1:0] head_entry;

`ifdef TOKEN_RUN_FLUSH_EN
    assign end_run = !a || flush;
`else
    assign end_run = !a;
`endif

    // Zero-length runs never produce an entry.
    assign push       = end_run && (cnt_q != '0);
    assign push_entry = {sat_q, cnt_q};
    assign pop        = !empty && run_if.run_ready;

    always_comb begin
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        drop_err_d = drop_err_q;
        if (push) begin
            // A flushed run with a=1 still owns the current bit as its first.
            cnt_d = a ? LEN_W'(1) : '0;
            sat_d = 1'b0;
        end else if (a) begin
            if (cnt_q == CntMax) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
        if (push && full && !pop) begin
            drop_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            drop_err_q <= drop_err_d;
        end
    end

    token_run_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head_entry),
        .full_o  (full),
        .empty_o (empty)
    );

    assign run_if.run_valid = !empty;
    assign run_if.run_len   = head_entry[LEN_W-1:0];
    assign run_if.run_sat   = head_entry[LEN_W];
    assign drop_err         = drop_err_q;

endmodule

// File: tb/tb_token_run_counter.sv
// Scoreboard bench for token_run_counter: queue-based reference model plus decoupled monitor.
// Define TOKEN_RUN_FLUSH_EN to also exercise the flush input.
module tb_token_run_counter;
    import token_run_pkg::*;

    localparam int unsigned LenW   = DefaultLenW;
    localparam int unsigned Depth  = DefaultDepth;
    localparam int          MaxLen = (1 << LenW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic drop_err;
`ifdef TOKEN_RUN_FLUSH_EN
    logic flush_v;
`endif

    token_run_counter_if #(.LEN_W(LenW)) run_if ();

    token_run_counter #(
        .LEN_W (LenW),
        .DEPTH (Depth)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
`ifdef TOKEN_RUN_FLUSH_EN
        .flush    (flush_v),
`endif
        .run_if   (run_if),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    int         vectors    = 0;
    int         miscompares = 0;
    run_entry_t mq[$];     // model FIFO contents
    run_entry_t sb_q[$];   // expected deliveries, popped by the monitor
    int         len_m = 0; // length of the run in progress, unbounded
    bit         drop_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and advance the reference model across the edge.
    task automatic step(input logic av, input logic rv, input logic fv);
        run_entry_t e;
        bit         pop_m;
        bit         push_m;
        a                = av;
        run_if.run_ready = rv;
`ifdef TOKEN_RUN_FLUSH_EN
        flush_v = fv;
`else
        fv = 1'b0;
`endif
        @(posedge clk);
        pop_m  = (mq.size() > 0) && rv;
        push_m = (!av || fv) && (len_m > 0);
        e      = '0;
        if (push_m) begin
            e.sat = (len_m > MaxLen);
            e.len = LenW'((len_m > MaxLen) ? MaxLen : len_m);
            len_m = av ? 1 : 0;
        end else if (av) begin
            len_m++;
        end
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            if (mq.size() < int'(Depth)) begin
                mq.push_back(e);
                sb_q.push_back(e);
            end else begin
                drop_m = 1'b1;
            end
        end
        #1;
    endtask

    task automatic run_bits(input logic [63:0] bits, input int n, input logic rv);
        for (int i = n - 1; i >= 0; i--) step(bits[i], rv, 1'b0);
    endtask

    // Assert reset between clock edges and check outputs clear without waiting for a clock.
    task automatic async_reset();
        a                = 1'b0;
        run_if.run_ready = 1'b0;
`ifdef TOKEN_RUN_FLUSH_EN
        flush_v = 1'b0;
`endif
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        sb_q.delete();
        len_m  = 0;
        drop_m = 1'b0;
        check("rst_run_valid", run_if.run_valid, 0);
        check("rst_run_len", run_if.run_len, 0);
        check("rst_run_sat", run_if.run_sat, 0);
        check("rst_drop_err", drop_err, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle state checks plus scoreboard pops on every handshake.
    initial begin : monitor
        run_entry_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                check("run_valid", run_if.run_valid, mq.size() > 0);
                check("drop_err", drop_err, drop_m);
                check("fifo_count", dut.u_fifo.count_q, mq.size());
                if (run_if.run_valid && run_if.run_ready) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_entry: got len %0d, expected no entry (t=%0t)",
                                 run_if.run_len, $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("run_len", run_if.run_len, e.len);
                        check("run_sat", run_if.run_sat, e.sat);
                    end
                end else if (!run_if.run_valid) begin
                    check("idle_run_len", run_if.run_len, 0);
                    check("idle_run_sat", run_if.run_sat, 0);
                end
            end
        end
    end

    initial begin : stimulus
        bit slow;
        logic av;
        logic rv;
        logic fv;
        rst              = 1'b0;
        a                = 1'b0;
        run_if.run_ready = 1'b0;
`ifdef TOKEN_RUN_FLUSH_EN
        flush_v = 1'b0;
`endif
        async_reset();

        // Two short runs, consumer always ready.
        run_bits(64'b0110111000, 10, 1'b1);

        // Long runs around the saturation boundary.
        repeat (400) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (520) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (511) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (512) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Consumer stalled: fifth run overflows, drop_err must stick after draining.
        run_bits(64'b10101010100, 11, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Full FIFO with a pop on the push edge: no drop.
        async_reset();
        run_bits(64'b10101010, 8, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-run with entries queued, then a clean short run.
        async_reset();
        run_bits(64'b110110, 6, 1'b0);
        repeat (7) step(1'b1, 1'b0, 1'b0);
        async_reset();
        run_bits(64'b110, 3, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

`ifdef TOKEN_RUN_FLUSH_EN
        // Flush mid-run splits ten ones into 5 + 5; flush on an idle counter does nothing.
        async_reset();
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, i == 5);
        repeat (3) step(1'b0, 1'b1, 1'b0);
`endif

        // Randomised traffic with bursty consumer stalls and occasional long runs.
        async_reset();
        slow = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) slow = bit'($urandom_range(1, 0));
            rv = slow ? ($urandom_range(7, 0) == 0) : ($urandom_range(3, 0) != 0);
            av = ($urandom_range(99, 0) < 60);
`ifdef TOKEN_RUN_FLUSH_EN
            fv = ($urandom_range(15, 0) == 0);
`else
            fv = 1'b0;
`endif
            if ($urandom_range(199, 0) == 0) begin
                repeat ($urandom_range(560, 480)) step(1'b1, rv, 1'b0);
            end
            step(av, rv, fv);
        end
        repeat (12) step(1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/token_run_counter.md
Name: token_run_counter

Overview:
- Downstream consumer of the doubled serial token stream; sits directly after the token-doubling stage.
- Measures the length of every run of consecutive '1' bits on the serial input.
- Buffers completed run lengths in a small FIFO and delivers them over a valid/ready interface to a parallel consumer.
- Flags saturation of individual runs, plus sticky FIFO-drop errors.

Parameters:
- LEN_W, 9, run-length field width; max reportable length is 2^LEN_W-1 (511 by default, which covers a doubled 200-token run of 400).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  1  serial token stream, sampled every clk.
- run_valid  output  1  head FIFO entry available.
- run_ready  input  1  consumer accepts head entry when run_valid is high.
- run_len  output  LEN_W  length of the completed run at the FIFO head.
- run_sat  output  1  head run reached 2^LEN_W-1 and saturated.
- drop_err  output  1  sticky: a completed run was lost because the FIFO was full.

Behaviour:
- Reset: clk and rst as named; reset is asynchronous, active-high. Mid-operation reset clears at once, asynchronously:
  - counter = 0, sat = 0, FIFO empty.
  - run_valid = 0, run_len = 0, run_sat = 0, drop_err = 0.
  - An in-progress run is discarded; no partial entry is pushed.
- Run counter cnt (LEN_W bits) plus sat flag:
  - a=1: cnt increments, saturating at 2^LEN_W-1. sat sets on the edge where cnt would exceed the max.
  - a=0 and cnt!=0: push {sat,cnt} at this edge; cnt and sat clear.
  - a=0 and cnt=0: idle, no push.
  - Zero-length runs are never reported.
- Latency:
  - With the FIFO empty, run_valid rises in the cycle after the edge that samples the terminating '0'.
  - run_len is stable while run_valid=1 and run_ready=0.
- FIFO behaviour:
  - Show-ahead: outputs present the head entry; run_len and run_sat are 0 when empty.
  - Pop on run_valid && run_ready.
  - Push while full and no pop: entry dropped, drop_err sets and stays set until rst.
  - Push and pop in the same cycle while full: both occur, no drop.
  - Push and pop in the same cycle while empty: the entry is pushed; run_valid rises next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived from a separate count register of width log2(DEPTH)+1.
- run_ready is ignored while run_valid=0.

Optional Feature:
- Macro: TOKEN_RUN_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 with cnt!=0 pushes {sat,cnt} at that edge even though a=1. cnt then restarts at 1 if a=1, or 0 if a=0.
  - flush with cnt=0 has no effect.
  - flush is subject to the same full/drop rules as a normal push.
- Undefined: no flush port; runs end only on a '0'.

Decomposition:
- Package token_run_pkg:
  - default LEN_W and DEPTH localparams.
  - typedef run_entry_t, a packed struct {sat, len[LEN_W-1:0]}.
- Sub-module token_run_fifo: synchronous show-ahead FIFO with async reset; ports push, entry in, pop, head out, full, empty.
- The top level holds the run counter, the push logic and drop_err.

Test Plan:
- a = 0110111000 with run_ready=1 -> two entries, run_len=2 then 3, run_sat=0; each run_valid pulse lasts 1 cycle and appears 1 cycle after the terminating 0.
- a = 400 ones then 0 (doubled 200-token run), run_ready=1 -> run_len=400, run_sat=0. Then 520 ones then 0 -> run_len=511, run_sat=1.
- run_ready=0; a = 10101010100 (5 runs of 1) -> first 4 entries held with lengths 1,1,1,1; 5th run dropped; drop_err=1. drop_err stays 1 after draining, until rst.
- FIFO full with run_ready=1 held during a push edge -> no drop, drop_err=0, count stays 4.
- rst asserted asynchronously mid-run (cnt=7, 2 entries queued) -> outputs zero immediately. After release, a = 110 yields a single run_len=2.
- TOKEN_RUN_FLUSH_EN: a held at 1 for 10 cycles with flush pulsed on cycle 5 -> entries 5 then 5 (the second pushed on the terminating 0).
